stream_serializer: RTL and testbench

- Parametrised width-reducing serializer. Splits one FROM-bit input word into FROM/TO consecutive TO-bit output beats.
- Uses a full valid/ready handshake on both sides. Output backpressure is honoured.
- Accepts the next word during the last beat of the current word, so a continuous input stream leaves no bubble cycles.
- Sits between a wide datapath and a narrow link or lane. Replaces the fixed-ratio, no-backpressure serializer.

---
 rtl/stream_serializer_if.sv | 26 ++
 rtl/stream_serializer.sv | 106 ++++++++++
 tb/tb_stream_serializer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_serializer_if.sv
// Handshake bundle for stream_serializer: a wide input word stream on the
// upstream side and a narrow beat stream on the downstream side.
interface stream_serializer_if #(
  parameter int FROM = 8,
  parameter int TO   = 1
);
  logic [FROM-1:0] data_i;
  logic            valid_i;
  logic            ready_o;
  logic [TO-1:0]   data_o;
  logic            valid_o;
  logic            ready_i;
  logic            last_o;

  // Environment side: sources words and sinks beats.
  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, last_o
  );

  // Serializer side.
  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, last_o
  );
endinterface

// File: rtl/stream_serializer.sv
// Width-reducing serializer: one FROM-bit word becomes FROM/TO TO-bit beats,
// with valid/ready on both sides. The next word is accepted during the final
// beat so a continuous stream runs without bubbles.
module stream_serializer #(
  parameter int FROM      = 8,
  parameter int TO        = 1,
  parameter int LSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  stream_serializer_if.slave  bus
);

  localparam int BEATS = FROM / TO;
  localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [FROM-1:0] sreg_q, sreg_d;
  logic [FROM-1:0] sreg_adv;
  logic            last_beat;
  logic            ready;
  logic            valid;
  logic            in_fire;
  logic            out_fire;

  if ((TO < 1) || (TO > FROM) || ((FROM % TO) != 0)) begin : g_bad_params
    $error("stream_serializer: FROM (%0d) must be a multiple of TO (%0d) with 1 <= TO <= FROM",
           FROM, TO);
  end

  // The outgoing beat always sits at the register edge nearest the output,
  // so data_o is a plain register slice and advancing is a fixed shift.
  if (LSB_FIRST != 0) begin : g_lsb
    assign bus.data_o = sreg_q[TO-1:0];
    assign sreg_adv   = sreg_q >> TO;
  end else begin : g_msb
    assign bus.data_o = sreg_q[FROM-1 -: TO];
    assign sreg_adv   = sreg_q << TO;
  end

  // ready_o depends only on state and ready_i, never on valid_i; in IDLE it
  // is gated by reset_n so it reads 0 while reset is held.
  assign valid       = (state_q == SEND);
  assign last_beat   = valid && (cnt_q == LAST_CNT);
  assign ready       = (state_q == IDLE) ? reset_n : (last_beat & bus.ready_i);
  assign in_fire     = bus.valid_i & ready;
  assign out_fire    = valid & bus.ready_i;

  assign bus.valid_o = valid;
  assign bus.last_o  = last_beat;
  assign bus.ready_o = ready;

  // Next-state logic: load on accept, shift on non-final beats, reload or
  // drop to IDLE on the final beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          sreg_d  = bus.data_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (last_beat) begin
            cnt_d = '0;
            if (in_fire) begin
              sreg_d = bus.data_i;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sreg_d = sreg_adv;
            cnt_d  = cnt_q + CNTW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, beat counter and shift register; all cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: three instances (8->2 LSB-first, 8->2
// MSB-first, 4->4), directed vectors plus a randomized run against a
// beat-queue reference model.
module tb_stream_serializer;

  logic clk;
  logic reset_n;

  stream_serializer_if #(.FROM(8), .TO(2)) if_l ();
  stream_serializer_if #(.FROM(8), .TO(2)) if_m ();
  stream_serializer_if #(.FROM(4), .TO(4)) if_d ();

  stream_serializer #(.FROM(8), .TO(2), .LSB_FIRST(1)) u_lsb (.clk(clk), .reset_n(reset_n), .bus(if_l));
  stream_serializer #(.FROM(8), .TO(2), .LSB_FIRST(0)) u_msb (.clk(clk), .reset_n(reset_n), .bus(if_m));
  stream_serializer #(.FROM(4), .TO(4), .LSB_FIRST(1)) u_deg (.clk(clk), .reset_n(reset_n), .bus(if_d));

  // Uniform views of the three instances: index 0 = lsb, 1 = msb, 2 = deg.
  logic [7:0] din  [3];
  logic       vin  [3];
  logic       rin  [3];
  logic [7:0] dout [3];
  logic       vout [3];
  logic       rout [3];
  logic       lout [3];

  assign if_l.data_i  = din[0];
  assign if_l.valid_i = vin[0];
  assign if_l.ready_i = rin[0];
  assign if_m.data_i  = din[1];
  assign if_m.valid_i = vin[1];
  assign if_m.ready_i = rin[1];
  assign if_d.data_i  = din[2][3:0];
  assign if_d.valid_i = vin[2];
  assign if_d.ready_i = rin[2];

  assign dout[0] = {6'b0, if_l.data_o};
  assign dout[1] = {6'b0, if_m.data_o};
  assign dout[2] = {4'b0, if_d.data_o};
  assign vout[0] = if_l.valid_o;
  assign vout[1] = if_m.valid_o;
  assign vout[2] = if_d.valid_o;
  assign rout[0] = if_l.ready_o;
  assign rout[1] = if_m.ready_o;
  assign rout[2] = if_d.ready_o;
  assign lout[0] = if_l.last_o;
  assign lout[1] = if_m.last_o;
  assign lout[2] = if_d.last_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_en    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: expected beats packed beat0 in [7:6] .. beat3 in [1:0].
  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
  } vec_t;

  vec_t vecs [4];

  // Send one word on the lsb instance (and the msb instance if use_m) with
  // ready_i high, checking each beat, last_o, ready_o and the valid drop.
  task automatic send_chk(input logic [7:0] w, input logic [7:0] el,
                          input logic [7:0] em, input bit use_m);
    din[0] = w; vin[0] = 1'b1;
    if (use_m) begin din[1] = w; vin[1] = 1'b1; end
    @(negedge clk);
    chk("idle_ready_l", rout[0], 1'b1);
    step();
    vin[0] = 1'b0; vin[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("beat_l", dout[0], el[7-2*k -: 2]);
      chk("valid_l", vout[0], 1'b1);
      chk("last_l", lout[0], (k == 3));
      chk("ready_l", rout[0], (k == 3));
      if (use_m) begin
        chk("beat_m", dout[1], em[7-2*k -: 2]);
        chk("last_m", lout[1], (k == 3));
      end
      step();
    end
    @(negedge clk);
    chk("valid_fall_l", vout[0], 1'b0);
    if (use_m) chk("valid_fall_m", vout[1], 1'b0);
    step();
  endtask

  // Reference model: per instance, a FIFO of {last, beat} still owed.
  int         p_from [3] = '{8, 8, 4};
  int         p_to   [3] = '{2, 2, 4};
  bit         p_lsb  [3] = '{1'b1, 1'b0, 1'b1};
  logic [8:0] mq     [3][16];
  int         mhead  [3] = '{0, 0, 0};
  int         mcnt   [3] = '{0, 0, 0};

  initial begin
    forever begin
      @(negedge clk);
      if (sb_en) begin
        for (int i = 0; i < 3; i++) begin
          logic exp_v, exp_r;
          exp_v = (mcnt[i] != 0);
          exp_r = (mcnt[i] == 0) || ((mcnt[i] == 1) && rin[i]);
          chk("rand_valid", vout[i], exp_v);
          chk("rand_ready", rout[i], exp_r);
          if (exp_v) begin
            chk("rand_data", dout[i], mq[i][mhead[i]][7:0]);
            chk("rand_last", lout[i], mq[i][mhead[i]][8]);
          end
          if (exp_v && rin[i]) begin
            mhead[i] = (mhead[i] + 1) % 16;
            mcnt[i]--;
          end
          if (exp_r && vin[i]) begin
            for (int k = 0; k < p_from[i] / p_to[i]; k++) begin
              int         sh;
              logic [7:0] b;
              sh = p_lsb[i] ? (k * p_to[i]) : (p_from[i] - (k + 1) * p_to[i]);
              b  = 8'((din[i] >> sh) & ((1 << p_to[i]) - 1));
              mq[i][(mhead[i] + mcnt[i]) % 16] = {(k == p_from[i] / p_to[i] - 1), b};
              mcnt[i]++;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] seq;

    vecs[0] = '{word: 8'hB4, exp_lsb: 8'h1E, exp_msb: 8'hB4};
    vecs[1] = '{word: 8'h3C, exp_lsb: 8'h3C, exp_msb: 8'h3C};
    vecs[2] = '{word: 8'h01, exp_lsb: 8'h40, exp_msb: 8'h01};
    vecs[3] = '{word: 8'hE4, exp_lsb: 8'h1B, exp_msb: 8'hE4};

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din[i] = 8'h00; vin[i] = 1'b0; rin[i] = 1'b1;
    end

    // Reset state
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", vout[i], 1'b0);
      chk("rst_last",  lout[i], 1'b0);
      chk("rst_data",  dout[i], 8'h00);
      chk("rst_ready", rout[i], 1'b0);
    end
    step();
    step();
    reset_n = 1'b1;

    // Basic LSB-first and MSB-first from the table
    for (int v = 0; v < 4; v++) begin
      send_chk(vecs[v].word, vecs[v].exp_lsb, vecs[v].exp_msb, 1'b1);
    end

    // Back-to-back 0xB4 then 0x3C with valid_i held
    seq = {vecs[0].exp_lsb, vecs[1].exp_lsb};
    din[0] = 8'hB4; vin[0] = 1'b1;
    @(negedge clk);
    chk("b2b_ready_idle", rout[0], 1'b1);
    step();
    din[0] = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_beat",  dout[0], seq[15-2*k -: 2]);
      chk("b2b_valid", vout[0], 1'b1);
      chk("b2b_last",  lout[0], (k == 3) || (k == 7));
      chk("b2b_ready", rout[0], (k == 3) || (k == 7));
      step();
      if (k == 3) vin[0] = 1'b0;
    end
    @(negedge clk);
    chk("b2b_valid_fall", vout[0], 1'b0);
    step();

    // Backpressure: stall three cycles on beat 2 (01)
    din[0] = 8'hB4; vin[0] = 1'b1;
    step();
    vin[0] = 1'b0;
    @(negedge clk);
    chk("bp_beat0", dout[0], 2'b00);
    step();
    rin[0] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("bp_stall_data",  dout[0], 2'b01);
      chk("bp_stall_valid", vout[0], 1'b1);
      chk("bp_stall_last",  lout[0], 1'b0);
      chk("bp_stall_ready", rout[0], 1'b0);
      step();
    end
    rin[0] = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("bp_resume_beat", dout[0], vecs[0].exp_lsb[7-2*k -: 2]);
      chk("bp_resume_last", lout[0], (k == 3));
      step();
    end
    @(negedge clk);
    chk("bp_valid_fall", vout[0], 1'b0);
    step();

    // Reset asserted mid-word during beat 2 of 0xB4
    din[0] = 8'hB4; vin[0] = 1'b1;
    step();
    vin[0] = 1'b0;
    step();
    @(negedge clk);
    chk("mid_beat1", dout[0], 2'b01);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", vout[0], 1'b0);
    chk("mid_rst_last",  lout[0], 1'b0);
    chk("mid_rst_data",  dout[0], 8'h00);
    chk("mid_rst_ready", rout[0], 1'b0);
    step();
    reset_n = 1'b1;
    send_chk(8'h3C, vecs[1].exp_lsb, vecs[1].exp_msb, 1'b0);

    // Degenerate ratio 4->4: 5, A, F back-to-back
    din[2] = 8'h05; vin[2] = 1'b1;
    step();
    din[2] = 8'h0A;
    @(negedge clk);
    chk("deg_beat5",  dout[2], 8'h05);
    chk("deg_last5",  lout[2], 1'b1);
    chk("deg_ready5", rout[2], 1'b1);
    step();
    din[2] = 8'h0F;
    @(negedge clk);
    chk("deg_beatA", dout[2], 8'h0A);
    chk("deg_lastA", lout[2], 1'b1);
    step();
    vin[2] = 1'b0;
    @(negedge clk);
    chk("deg_beatF",  dout[2], 8'h0F);
    chk("deg_validF", vout[2], 1'b1);
    step();
    @(negedge clk);
    chk("deg_valid_fall", vout[2], 1'b0);
    step();

    // Randomized traffic against the reference model, then drain
    sb_en = 1'b1;
    repeat (600) begin
      for (int i = 0; i < 3; i++) begin
        din[i] = 8'($urandom);
        vin[i] = ($urandom_range(0, 3) != 0);
        rin[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; rin[i] = 1'b1;
    end
    repeat (12) step();
    sb_en = 1'b0;
    for (int i = 0; i < 3; i++) chk("drain_empty", vout[i], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
